// File: rtl/debug_out_port_pkg.sv
// Shared definitions for the debug output port: default geometry,
// FIFO entry width and the full-FIFO policy encoding.
package debug_out_port_pkg;

    localparam int DBG_DATA_WIDTH = 32;
    localparam int DBG_CHANNELS   = 4;
    localparam int DBG_CH_BITS    = 2;
    localparam int DBG_DEPTH      = 16;
    localparam int DBG_PTR_BITS   = 4;

    // A queued entry is {channel, data}
    localparam int DBG_ENTRY_W = DBG_CH_BITS + DBG_DATA_WIDTH;

    // Full-FIFO write policy selected by overwrite_mode
    localparam logic DBG_MODE_DROP      = 1'b0;
    localparam logic DBG_MODE_OVERWRITE = 1'b1;

    function automatic int dbg_entry_w(input int ch_bits, input int data_width);
        return ch_bits + data_width;
    endfunction

endpackage

// File: rtl/debug_out_port_if.sv
// Debug port bus: CPDR store strobe from the core plus the valid/ready
// stream that a host, UART or LED scanner drains.
// slave  : the debug port itself
// master : the surrounding core/consumer environment
interface debug_out_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_BITS    = 2
) ();
    logic                  wr_en;
    logic [CH_BITS-1:0]    wr_chan;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CH_BITS-1:0]    out_chan;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output wr_en, wr_chan, wr_data, out_ready,
        input  out_valid, out_chan, out_data
    );

    modport slave (
        input  wr_en, wr_chan, wr_data, out_ready,
        output out_valid, out_chan, out_data
    );
endinterface

// File: rtl/debug_fifo.sv
// Synchronous FIFO with a selectable full policy: drop the incoming
// entry, or discard the oldest one to make room. Head is read straight
// from storage; out-of-range head data is forced to zero so it stays
// stable (and zero after reset) while the FIFO is empty.
module debug_fifo
    import debug_out_port_pkg::*;
#(
    parameter int ENTRY_W  = DBG_ENTRY_W,
    parameter int DEPTH    = DBG_DEPTH,
    parameter int PTR_BITS = DBG_PTR_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [ENTRY_W-1:0]  push_data,
    input  logic                pop_ready,
    input  logic                overwrite_mode,
    input  logic                clear,
    output logic                head_valid,
    output logic [ENTRY_W-1:0]  head_data,
    output logic [PTR_BITS:0]   count,
    output logic                overflow
);

    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS + 1)'(DEPTH);

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [PTR_BITS-1:0] rptr;
    logic [PTR_BITS-1:0] wptr;
    logic [PTR_BITS:0]   count_nxt;
    logic                full;
    logic                pop;
    logic                wr_ok;
    logic                rd_adv;
    logic                ovf_set;

    // Decide which pointers move this cycle and the resulting occupancy
    always_comb begin
        full      = (count == FULL_CNT);
        pop       = (count != '0) && pop_ready;
        // A pop on a full FIFO frees a slot, so the push always lands then
        wr_ok     = push && (!full || pop || (overwrite_mode == DBG_MODE_OVERWRITE));
        rd_adv    = pop || (push && full && !pop && (overwrite_mode == DBG_MODE_OVERWRITE));
        ovf_set   = push && full && !pop;
        count_nxt = count;
        if (wr_ok && !rd_adv) begin
            count_nxt = count + 1'b1;
        end else if (rd_adv && !wr_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointer, occupancy and sticky overflow state; clear beats push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)   wptr     <= wptr + 1'b1;
            if (rd_adv)  rptr     <= rptr + 1'b1;
            if (ovf_set) overflow <= 1'b1;
            count <= count_nxt;
        end
    end

    // Entry storage; contents need no reset because count gates the head
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) begin
            mem[wptr] <= push_data;
        end
    end

    // Present the head entry
    always_comb begin
        head_valid = (count != '0);
        head_data  = head_valid ? mem[rptr] : '0;
    end

endmodule

// File: rtl/debug_out_port.sv
// Parametrised CPDR debug output: per-channel shadow registers of the
// last value written, plus a FIFO of every write for a draining consumer.
module debug_out_port
    import debug_out_port_pkg::*;
#(
    parameter int DATA_WIDTH = DBG_DATA_WIDTH,
    parameter int CHANNELS   = DBG_CHANNELS,
    parameter int CH_BITS    = DBG_CH_BITS,
    parameter int DEPTH      = DBG_DEPTH,
    parameter int PTR_BITS   = DBG_PTR_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    debug_out_port_if.slave                bus,
    input  logic                           overwrite_mode,
    input  logic                           clear,
    output logic [CHANNELS*DATA_WIDTH-1:0] dr_flat,
    output logic [PTR_BITS:0]              count,
    output logic                           overflow
);

    localparam int ENTRY_W = dbg_entry_w(CH_BITS, DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shadow [CHANNELS];
    logic                  head_valid;
    logic [ENTRY_W-1:0]    head_data;

    // Latch the last value per channel; independent of FIFO state and clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                shadow[k] <= '0;
            end
        end else if (bus.wr_en) begin
            shadow[bus.wr_chan] <= bus.wr_data;
        end
    end

    // Flatten shadows, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
    always_comb begin
        dr_flat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            dr_flat[k*DATA_WIDTH +: DATA_WIDTH] = shadow[k];
        end
    end

    debug_fifo #(
        .ENTRY_W  (ENTRY_W),
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push           (bus.wr_en),
        .push_data      ({bus.wr_chan, bus.wr_data}),
        .pop_ready      (bus.out_ready),
        .overwrite_mode (overwrite_mode),
        .clear          (clear),
        .head_valid     (head_valid),
        .head_data      (head_data),
        .count          (count),
        .overflow       (overflow)
    );

    assign bus.out_valid = head_valid;
    assign bus.out_chan  = head_data[ENTRY_W-1:DATA_WIDTH];
    assign bus.out_data  = head_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_debug_out_port.sv
// Bench for debug_out_port: directed scenarios then random traffic, all
// compared each cycle against a queue-based reference model.
module tb_debug_out_port;

    localparam int DW    = 32;
    localparam int CH    = 4;
    localparam int CB    = 2;
    localparam int DEPTH = 16;
    localparam int PB    = 4;

    typedef struct {
        logic [CB-1:0] ch;
        logic [DW-1:0] d;
    } entry_t;

    logic              clk;
    logic              reset;
    logic              overwrite_mode;
    logic              clear;
    logic [CH*DW-1:0]  dr_flat;
    logic [PB:0]       count;
    logic              overflow;

    debug_out_port_if #(.DATA_WIDTH(DW), .CH_BITS(CB)) bus ();

    debug_out_port #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .CH_BITS    (CB),
        .DEPTH      (DEPTH),
        .PTR_BITS   (PB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .overwrite_mode (overwrite_mode),
        .clear          (clear),
        .dr_flat        (dr_flat),
        .count          (count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    entry_t        m_q[$];
    logic [DW-1:0] m_shadow [CH];
    logic          m_ovf;

    task automatic chk(input string tag, input logic [CH*DW-1:0] obs, input logic [CH*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < CH; k++) m_shadow[k] = '0;
        m_ovf = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour to the reference model
    task automatic model_edge();
        entry_t e;
        if (bus.wr_en) m_shadow[bus.wr_chan] = bus.wr_data;
        if (clear) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
            if (bus.wr_en) begin
                e.ch = bus.wr_chan;
                e.d  = bus.wr_data;
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (overwrite_mode) begin
                        void'(m_q.pop_front());
                        m_q.push_back(e);
                    end
                end
            end
        end
    endtask

    function automatic logic [CH*DW-1:0] model_flat();
        logic [CH*DW-1:0] f;
        f = '0;
        for (int k = 0; k < CH; k++) f[k*DW +: DW] = m_shadow[k];
        return f;
    endfunction

    task automatic compare_all(input string ph);
        chk({ph, "/valid"},    CH*DW'(bus.out_valid), CH*DW'(m_q.size() != 0));
        chk({ph, "/count"},    CH*DW'(count),         CH*DW'(m_q.size()));
        chk({ph, "/overflow"}, CH*DW'(overflow),      CH*DW'(m_ovf));
        chk({ph, "/dr_flat"},  dr_flat,               model_flat());
        if (m_q.size() != 0) begin
            chk({ph, "/out_chan"}, CH*DW'(bus.out_chan), CH*DW'(m_q[0].ch));
            chk({ph, "/out_data"}, CH*DW'(bus.out_data), CH*DW'(m_q[0].d));
        end
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ph);
    endtask

    task automatic drive(input logic wr, input logic [CB-1:0] ch, input logic [DW-1:0] d,
                         input logic rdy, input logic clr);
        bus.wr_en     = wr;
        bus.wr_chan   = ch;
        bus.wr_data   = d;
        bus.out_ready = rdy;
        clear         = clr;
    endtask

    task automatic fill16();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, CB'(i % CH), DW'(i), 1'b0, 1'b0);
            cycle("fill");
        end
    endtask

    initial begin
        reset          = 1'b1;
        overwrite_mode = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        #3 reset = 1'b0;

        // Single write to channel 2
        drive(1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 1'b0);
        cycle("t1");
        chk("t1_shadow2", CH*DW'(dr_flat[95:64]), CH*DW'(32'hDEADBEEF));
        chk("t1_others",  CH*DW'({dr_flat[127:96], dr_flat[63:0]}), '0);
        chk("t1_valid",   CH*DW'(bus.out_valid), CH*DW'(1));
        chk("t1_chan",    CH*DW'(bus.out_chan),  CH*DW'(2));
        chk("t1_count",   CH*DW'(count),         CH*DW'(1));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle("t1_drain");

        // Drop mode: 17th write lost
        overwrite_mode = 1'b0;
        fill16();
        drive(1'b1, 2'd1, 32'h99, 1'b0, 1'b0);
        cycle("t2_full");
        chk("t2_count", CH*DW'(count),    CH*DW'(16));
        chk("t2_ovf",   CH*DW'(overflow), CH*DW'(1));
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_drain", CH*DW'(bus.out_data), CH*DW'(i));
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            cycle("t2_drain");
        end
        chk("t2_empty", CH*DW'(bus.out_valid), '0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle("t2_clear");

        // Overwrite mode: oldest discarded
        overwrite_mode = 1'b1;
        fill16();
        drive(1'b1, 2'd1, 32'h99, 1'b0, 1'b0);
        cycle("t3_full");
        chk("t3_count", CH*DW'(count),    CH*DW'(16));
        chk("t3_ovf",   CH*DW'(overflow), CH*DW'(1));
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain", CH*DW'(bus.out_data), CH*DW'((i < 15) ? i + 1 : 32'h99));
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            cycle("t3_drain");
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle("t3_clear");

        // Full FIFO with simultaneous push and pop
        overwrite_mode = 1'b0;
        fill16();
        drive(1'b1, 2'd3, 32'hAA, 1'b1, 1'b0);
        cycle("t4_pushpop");
        chk("t4_count", CH*DW'(count),    CH*DW'(16));
        chk("t4_ovf",   CH*DW'(overflow), '0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_drain", CH*DW'(bus.out_data), CH*DW'((i < 15) ? i + 1 : 32'hAA));
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            cycle("t4_drain");
        end

        // Clear together with a write
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, DW'(32'h100 + i), 1'b0, 1'b0);
            cycle("t5_fill");
        end
        drive(1'b1, 2'd1, 32'h55, 1'b0, 1'b1);
        cycle("t5_clear");
        chk("t5_count",   CH*DW'(count),          '0);
        chk("t5_valid",   CH*DW'(bus.out_valid),  '0);
        chk("t5_ovf",     CH*DW'(overflow),       '0);
        chk("t5_shadow1", CH*DW'(dr_flat[63:32]), CH*DW'(32'h55));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ((i % 100) == 0) overwrite_mode = 1'($urandom_range(0, 1));
            drive(($urandom_range(0, 99) < 60), CB'($urandom), $urandom,
                  ($urandom_range(0, 99) < (((i / 50) % 2 == 0) ? 25 : 85)),
                  ($urandom_range(0, 63) == 0));
            cycle("rand");
        end

        // Asynchronous reset in the middle of a drain
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle("t6_clear");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, CB'(i), DW'(32'hC0 + i), 1'b0, 1'b0);
            cycle("t6_fill");
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle("t6_drain");
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_valid",   CH*DW'(bus.out_valid), '0);
        chk("t6_count",   CH*DW'(count),         '0);
        chk("t6_dr_flat", dr_flat,               '0);
        #1 reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle("t6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
